// File: rtl/de2_70_onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip memory with one-cycle read latency.
// Round-robin on contention; read data is steered back to the master that issued the read.
//
// state   | meaning
// IDLE    | no read data due to this master in the current cycle
// RD_WAIT | memory read data for this master is valid in the current cycle
module de2_70_onchip_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_t;

    rd_state_t          state_m0;
    rd_state_t          state_m1;
    logic               last_grant;
    logic [ADDR_W-1:0]  addr_q;

    logic req0, req1;
    logic gnt0, gnt1;
    logic accept;
    logic rd_acc0, rd_acc1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // last_grant = 1 means master 1 was served last, so master 0 wins the next contention.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            if (req0 && req1) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign accept  = gnt0 | gnt1;
    assign rd_acc0 = gnt0 & m0_read & ~m0_write;
    assign rd_acc1 = gnt1 & m1_read & ~m1_write;

    assign m0_waitrequest = reset_n & req0 & ~gnt0;
    assign m1_waitrequest = reset_n & req1 & ~gnt1;

    assign mem_address    = gnt1 ? m1_address : (gnt0 ? m0_address : addr_q);
    assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gnt1 ? m1_writedata : m0_writedata;
    assign mem_chipselect = accept;
    assign mem_write      = (gnt1 & m1_write) | (gnt0 & m0_write);
    assign mem_clken      = reset_n;

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = (state_m0 == RD_WAIT);
    assign m1_readdatavalid = (state_m1 == RD_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_m0   <= IDLE;
            state_m1   <= IDLE;
            last_grant <= 1'b1;
            addr_q     <= '0;
        end else begin
            state_m0 <= rd_acc0 ? RD_WAIT : IDLE;
            state_m1 <= rd_acc1 ? RD_WAIT : IDLE;
            if (accept) begin
                last_grant <= gnt1;
                addr_q     <= mem_address;
            end
        end
    end

endmodule

// File: tb/tb_de2_70_onchip_mem_arbiter.sv
// Directed bench for the on-chip memory arbiter: behavioural single-port RAM,
// shadow memory and a read-return scoreboard queue.
module tb_de2_70_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_readdata;

    typedef struct {
        int          owner;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     sb[$];
    logic [31:0] ram     [4096];
    logic [31:0] ref_mem [4096];
    logic [11:0] last_addr;
    int          checks = 0;
    int          errors = 0;
    int          pulses0, pulses1;

    always #5 clk = ~clk;

    de2_70_onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // Single-port RAM: write lands at the edge, read data appears one cycle later.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic r, input logic w, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    task automatic apply(input int owner, input logic r, input logic w, input logic [11:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        rd_exp_t e;
        last_addr = a;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end else if (r) begin
            e.owner = owner;
            e.data  = ref_mem[a];
            sb.push_back(e);
        end
    endtask

    // One bus cycle; g is the master expected to be granted (-1 = none).
    task automatic step(input int g);
        rd_exp_t e;
        @(negedge clk);
        check("wait0", 32'(m0_waitrequest), 32'((m0_read | m0_write) && g != 0));
        check("wait1", 32'(m1_waitrequest), 32'((m1_read | m1_write) && g != 1));
        check("chipselect", 32'(mem_chipselect), 32'(g >= 0));
        if (g == 0)      check("addr_m0", 32'(mem_address), 32'(m0_address));
        else if (g == 1) check("addr_m1", 32'(mem_address), 32'(m1_address));
        else             check("addr_hold", 32'(mem_address), 32'(last_addr));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rdv0", 32'(m0_readdatavalid), 32'(e.owner == 0));
            check("rdv1", 32'(m1_readdatavalid), 32'(e.owner == 1));
            check("rdata", (e.owner == 0) ? m0_readdata : m1_readdata, e.data);
            if (e.owner == 0) pulses0++; else pulses1++;
        end else begin
            check("rdv0_idle", 32'(m0_readdatavalid), 32'd0);
            check("rdv1_idle", 32'(m1_readdatavalid), 32'd0);
        end
        if (g == 0) apply(0, m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
        if (g == 1) apply(1, m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_clken", 32'(mem_clken), 32'd0);
        check("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
        check("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
        check("rst_wait0", 32'(m0_waitrequest), 32'd0);
        check("rst_wait1", 32'(m1_waitrequest), 32'd0);
    endtask

    task automatic idle_all();
        set_m0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        set_m1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 32'h5A00_0000 | 32'(i * 7);
            ref_mem[i] = 32'h5A00_0000 | 32'(i * 7);
        end
        mem_readdata = 32'h0;
        last_addr    = 12'h000;
        pulses0 = 0;
        pulses1 = 0;

        // Reset with both masters requesting: everything quiet.
        reset_n = 1'b0;
        set_m0(1'b1, 1'b0, 12'h001, 4'hF, 32'h0);
        set_m1(1'b1, 1'b0, 12'h002, 4'hF, 32'h0);
        check_reset_outputs();
        @(posedge clk);
        #1 reset_n = 1'b1;
        check("clken_run", 32'(mem_clken), 32'd1);

        // Simultaneous reads right after reset: m0 first, m1 one cycle later.
        step(0);
        set_m0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step(1);
        idle_all();
        step(-1);

        // Continuous contention for 8 cycles: strict alternation.
        pulses0 = 0;
        pulses1 = 0;
        for (int i = 0; i < 8; i++) begin
            set_m0(1'b1, 1'b0, 12'h100 + 12'(i), 4'hF, 32'h0);
            set_m1(1'b1, 1'b0, 12'h200 + 12'(i), 4'hF, 32'h0);
            step(i % 2);
        end
        idle_all();
        step(-1);
        check("pulses_m0", 32'(pulses0), 32'd4);
        check("pulses_m1", 32'(pulses1), 32'd4);

        // Master 0 write then read back.
        set_m0(1'b0, 1'b1, 12'h010, 4'hF, 32'hDEAD_BEEF);
        step(0);
        set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
        step(0);
        idle_all();
        step(-1);

        // Partial-lane write at the top address, with the both-strobes-high write case.
        set_m0(1'b0, 1'b1, 12'hFFF, 4'hF, 32'hFFFF_FFFF);
        step(0);
        set_m0(1'b1, 1'b1, 12'hFFF, 4'h3, 32'h1234_5678);
        step(0);
        set_m0(1'b1, 1'b0, 12'hFFF, 4'hF, 32'h0);
        step(0);
        idle_all();
        step(-1);
        check("wrap_word", 32'(ref_mem[12'hFFF] == 32'hFFFF_5678), 32'(m0_readdatavalid === 1'b0));

        // Same-cycle m1 write and m0 read to one address; m0 was served last.
        set_m1(1'b0, 1'b1, 12'h020, 4'hF, 32'hCAFE_F00D);
        set_m0(1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
        step(1);
        set_m1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step(0);
        idle_all();
        step(-1);

        // Reset in the data-return cycle of an m1 read discards it.
        set_m1(1'b1, 1'b0, 12'h030, 4'hF, 32'h0);
        step(1);
        reset_n = 1'b0;
        sb.delete();
        last_addr = 12'h000;
        set_m0(1'b1, 1'b0, 12'h031, 4'hF, 32'h0);
        set_m1(1'b1, 1'b0, 12'h032, 4'hF, 32'h0);
        check_reset_outputs();
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(0);
        idle_all();
        step(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
